syscall_console_rx: RTL and testbench
=====================================

Name: syscall_console_rx

Overview:
- Receiving end of the data-memory syscall string channel.
- On a print-string syscall, the data memory streams the string bytes on a 32-bit char bus. Each new byte is flagged by toggling bit 8.
- This block synchronises that stream into the clk domain and pushes the bytes into a FIFO. It presents them on a valid/ready port to the console/testbench printer.
- It reports string completion, length, overflow and runaway-string errors.

Parameters:
- FIFO_DEPTH, 16, byte FIFO entries (power of 2, ≥2).
- SETTLE, 3, clk cycles waited after the synchronised syscall rising edge before the first byte is sampled.
- MAX_LEN, 255, bytes accepted before a string without NUL is aborted (1..255).
- NL_ON_END, 1, when 1 push 8'h0A into the FIFO on NUL.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- SyscallW  in  1  syscall-in-writeback level from the pipeline; asynchronous to clk
- char  in  32  string stream: [8]=toggle, [7:0]=byte, [31:9] ignored; asynchronous
- out_data  out  8  FIFO head byte
- out_valid  out  1  FIFO not empty
- out_ready  in  1  consumer accepts head when out_valid&out_ready
- busy  out  1  state != IDLE
- str_done  out  1  one-cycle pulse on NUL reception
- str_len  out  8  bytes received in current/last string (NUL and NL excluded)
- overflow  out  1  sticky: byte dropped because FIFO full
- len_err  out  1  sticky: MAX_LEN reached without NUL

Behaviour:
- Reset (async, rst_n=0): state IDLE; FIFO empty; all outputs 0; synchroniser flops 0; last_tog 0. Release is synchronous to clk.
- Synchronisation:
  - char[8:0] and SyscallW each pass through a 2-flop synchroniser.
  - Source guarantee: each byte and its toggle stay stable ≥4 clk cycles.
- Syscall edge: sync SyscallW 0→1 detected in the clk domain.
- IDLE:
  - On syscall edge: clear str_len, overflow, len_err; load settle counter = SETTLE; go ARM.
  - Toggle changes in IDLE are ignored, but last_tog still tracks the synced toggle.
- ARM:
  - Decrement the counter each cycle. At 0: sample the synced byte; last_tog := synced toggle; go PROCESS.
  - The first byte carries no toggle, hence the timed sample.
- RECV: when synced toggle != last_tog, sample the synced byte, last_tog := synced toggle, go PROCESS.
- PROCESS (one cycle):
  - Byte == 0:
    - If NL_ON_END, push 8'h0A.
    - Pulse str_done. Go IDLE.
  - Byte != 0:
    - Push the byte and increment str_len (saturating at 255).
    - If the new str_len == MAX_LEN: set len_err, go IDLE, no str_done.
    - Otherwise go RECV.
- FIFO:
  - Push is attempted only in PROCESS.
  - If full and no simultaneous pop: byte dropped, overflow set, str_len still increments.
  - If full with a simultaneous pop in the same cycle: the push succeeds.
  - Pop when out_valid&out_ready.
  - Pointers wrap modulo FIFO_DEPTH; count is tracked with one extra bit.
  - out_data is valid only while out_valid; it holds the head until it is popped.
  - The FIFO is not cleared by a new syscall; the consumer drains it across strings.
- Syscall edge while busy: ignored (no restart).
- A toggle change during ARM is ignored; the ARM sample covers it.
- rst_n low mid-string clears everything immediately, including FIFO contents.
- Latency: char change → PROCESS push is 3 clk (2 sync + 1 detect). out_valid rises 1 clk after the push.

Test Plan:
- "Hi\0" at a0 byte offset 0, syscall then toggles → FIFO pops 0x48, 0x69, 0x0A. str_done pulses once; str_len=2; overflow=0; len_err=0.
- Empty string (first byte 0x00) → str_done 1 cycle after ARM expires. Only 0x0A is pushed; str_len=0.
- out_ready=0 throughout, 20-char string, FIFO_DEPTH=16, NL_ON_END=1 → 16 bytes held, overflow=1, str_len=20. Draining later yields the first 16 chars in order.
- MAX_LEN=4, 6-char non-terminated stream → 4 bytes pushed, len_err=1, busy drops, no str_done. Later toggles are ignored until the next syscall.
- Back-to-back: second syscall 10 cycles after str_done, with the first char bearing the same toggle value as the prior NUL → first byte captured via ARM. overflow/len_err cleared; str_len restarts.
- rst_n asserted after 2 of 5 chars → all outputs 0 immediately, FIFO empty. A new syscall after release receives a full string correctly.

Source files
------------

// File: rtl/syscall_console_rx.sv
// Console receiver for the data-memory syscall string channel. It brings the
// toggle-flagged byte stream into the clk domain and queues the bytes in a FIFO.
module syscall_console_rx #(
    parameter int FIFO_DEPTH = 16,
    parameter int SETTLE     = 3,
    parameter int MAX_LEN    = 255,
    parameter bit NL_ON_END  = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        SyscallW,
    input  logic [31:0] char,
    output logic [7:0]  out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        busy,
    output logic        str_done,
    output logic [7:0]  str_len,
    output logic        overflow,
    output logic        len_err,
    output logic [1:0]  dbg_state
);
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [AW:0] DEPTH_C = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, ARM, RECV, PROCESS} state_t;

    state_t      state;
    logic [8:0]  char_s1, char_s2;
    logic        sys_s1, sys_s2, sys_s3;
    logic        sys_edge;
    logic [7:0]  settle_cnt;
    logic [7:0]  byte_q;
    logic        last_tog;
    logic [7:0]  next_len;

    logic [7:0]  mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0] count;
    logic        push_req, push_ok, pop, full;
    logic [7:0]  push_data;

    logic unused_char;
    assign unused_char = ^char[31:9];

    // Two-flop synchronisers; sys_s3 is the previous synced level for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            char_s1 <= '0;
            char_s2 <= '0;
            sys_s1  <= 1'b0;
            sys_s2  <= 1'b0;
            sys_s3  <= 1'b0;
        end else begin
            char_s1 <= char[8:0];
            char_s2 <= char_s1;
            sys_s1  <= SyscallW;
            sys_s2  <= sys_s1;
            sys_s3  <= sys_s2;
        end
    end

    assign sys_edge = sys_s2 & ~sys_s3;
    assign next_len = (str_len == 8'hFF) ? 8'hFF : str_len + 8'd1;

    // Handshake: a byte transfers on every cycle where out_valid and out_ready are
    // both high; out_data holds the head byte steadily until that transfer.
    assign out_valid = (count != '0);
    assign out_data  = out_valid ? mem[rd_ptr] : 8'h00;
    assign full      = (count == DEPTH_C);
    assign pop       = out_valid & out_ready;
    assign push_req  = (state == PROCESS) && ((byte_q != 8'h00) || NL_ON_END);
    assign push_data = (byte_q == 8'h00) ? 8'h0A : byte_q;
    assign push_ok   = push_req && (!full || pop);
    assign busy      = (state != IDLE);
    assign dbg_state = state;

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop)     rd_ptr <= rd_ptr + AW'(1);
            case ({push_ok, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            settle_cnt <= '0;
            byte_q     <= '0;
            last_tog   <= 1'b0;
            str_done   <= 1'b0;
            str_len    <= '0;
            overflow   <= 1'b0;
            len_err    <= 1'b0;
        end else begin
            str_done <= 1'b0;
            if (push_req && !push_ok) overflow <= 1'b1;
            case (state)
                IDLE: begin
                    last_tog <= char_s2[8];
                    if (sys_edge) begin
                        str_len    <= '0;
                        overflow   <= 1'b0;
                        len_err    <= 1'b0;
                        settle_cnt <= 8'(SETTLE);
                        state      <= ARM;
                    end
                end
                // The first byte arrives without a toggle, so it is sampled on a timer.
                ARM: begin
                    if (settle_cnt == 8'd0) begin
                        byte_q   <= char_s2[7:0];
                        last_tog <= char_s2[8];
                        state    <= PROCESS;
                    end else begin
                        settle_cnt <= settle_cnt - 8'd1;
                    end
                end
                RECV: begin
                    if (char_s2[8] != last_tog) begin
                        byte_q   <= char_s2[7:0];
                        last_tog <= char_s2[8];
                        state    <= PROCESS;
                    end
                end
                PROCESS: begin
                    if (byte_q == 8'h00) begin
                        str_done <= 1'b1;
                        state    <= IDLE;
                    end else begin
                        str_len <= next_len;
                        if (next_len == 8'(MAX_LEN)) begin
                            len_err <= 1'b1;
                            state   <= IDLE;
                        end else begin
                            state <= RECV;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_syscall_console_rx.sv
// Bench for syscall_console_rx: unit 0 uses default parameters, unit 1 uses
// MAX_LEN=4 for the runaway-string case.
module tb_syscall_console_rx;
    localparam int DEPTH = 16;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic        sys   [2];
    logic [31:0] chr   [2];
    logic        rdy   [2];
    logic        tog   [2];
    logic [7:0]  odata [2];
    logic        ovalid[2];
    logic        bsy   [2];
    logic        done  [2];
    logic [7:0]  slen  [2];
    logic        ovf   [2];
    logic        lerr  [2];
    logic [1:0]  dbg   [2];

    syscall_console_rx #(.FIFO_DEPTH(DEPTH), .SETTLE(3), .MAX_LEN(255), .NL_ON_END(1'b1)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .SyscallW(sys[0]), .char(chr[0]),
        .out_data(odata[0]), .out_valid(ovalid[0]), .out_ready(rdy[0]),
        .busy(bsy[0]), .str_done(done[0]), .str_len(slen[0]),
        .overflow(ovf[0]), .len_err(lerr[0]), .dbg_state(dbg[0])
    );

    syscall_console_rx #(.FIFO_DEPTH(DEPTH), .SETTLE(3), .MAX_LEN(4), .NL_ON_END(1'b1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .SyscallW(sys[1]), .char(chr[1]),
        .out_data(odata[1]), .out_valid(ovalid[1]), .out_ready(rdy[1]),
        .busy(bsy[1]), .str_done(done[1]), .str_len(slen[1]),
        .overflow(ovf[1]), .len_err(lerr[1]), .dbg_state(dbg[1])
    );

    int tests = 0;
    int fails = 0;

    logic [7:0] exp_q0[$], exp_q1[$];
    logic [7:0] pop_log0[$], pop_log1[$];
    bit m_busy[2], m_ovf[2], m_lerr[2];
    int m_len[2], m_done[2], done_seen[2];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int max_len(input int u);
        return (u == 0) ? 255 : 4;
    endfunction

    function automatic int q_size(input int u);
        return (u == 0) ? exp_q0.size() : exp_q1.size();
    endfunction

    function automatic logic [31:0] log_at(input int u, input int i);
        if (u == 0) return (i < pop_log0.size()) ? {24'd0, pop_log0[i]} : 32'hFFFF;
        return (i < pop_log1.size()) ? {24'd0, pop_log1[i]} : 32'hFFFF;
    endfunction

    // Model: bytes enter the expected queue while it has room, otherwise they are lost.
    task automatic q_push(input int u, input logic [7:0] b);
        if (q_size(u) < DEPTH) begin
            if (u == 0) exp_q0.push_back(b);
            else exp_q1.push_back(b);
        end else begin
            m_ovf[u] = 1'b1;
        end
    endtask

    task automatic model_start(input int u);
        if (!m_busy[u]) begin
            m_busy[u] = 1'b1;
            m_len[u]  = 0;
            m_ovf[u]  = 1'b0;
            m_lerr[u] = 1'b0;
        end
    endtask

    task automatic model_byte(input int u, input logic [7:0] b);
        if (!m_busy[u]) return;
        if (b == 8'h00) begin
            q_push(u, 8'h0A);
            m_done[u]++;
            m_busy[u] = 1'b0;
        end else begin
            q_push(u, b);
            if (m_len[u] < 255) m_len[u]++;
            if (m_len[u] == max_len(u)) begin
                m_lerr[u] = 1'b1;
                m_busy[u] = 1'b0;
            end
        end
    endtask

    task automatic model_reset();
        exp_q0.delete();
        exp_q1.delete();
        for (int u = 0; u < 2; u++) begin
            m_busy[u] = 1'b0;
            m_ovf[u]  = 1'b0;
            m_lerr[u] = 1'b0;
            m_len[u]  = 0;
        end
    endtask

    task automatic check_pop(input int u);
        logic [7:0] e;
        if (q_size(u) == 0) begin
            tests++;
            fails++;
            $display("FAIL pop%0d_unexpected: got %0h expected no byte", u, odata[u]);
        end else begin
            if (u == 0) e = exp_q0.pop_front();
            else e = exp_q1.pop_front();
            chk($sformatf("pop%0d", u), {24'd0, odata[u]}, {24'd0, e});
        end
        if (u == 0) pop_log0.push_back(odata[u]);
        else pop_log1.push_back(odata[u]);
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            for (int u = 0; u < 2; u++) begin
                if (ovalid[u] && rdy[u]) check_pop(u);
                if (done[u]) done_seen[u]++;
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic start_syscall(input int u, input logic [7:0] b);
        chr[u] = {23'd0, tog[u], b};
        sys[u] = 1'b1;
        model_start(u);
        model_byte(u, b);
        cyc(12);
        sys[u] = 1'b0;
    endtask

    task automatic send_byte(input int u, input logic [7:0] b);
        tog[u] = ~tog[u];
        chr[u] = {23'd0, tog[u], b};
        model_byte(u, b);
        cyc(6);
    endtask

    task automatic send_string(input int u, input string s, input bit nul);
        int n;
        logic [7:0] b;
        n = s.len() + (nul ? 1 : 0);
        for (int i = 0; i < n; i++) begin
            b = (i < s.len()) ? 8'(s[i]) : 8'h00;
            if (i == 0) start_syscall(u, b);
            else send_byte(u, b);
        end
        cyc(6);
    endtask

    task automatic check_state(input int u, input string tag);
        chk({tag, "_len"}, {24'd0, slen[u]}, m_len[u]);
        chk({tag, "_ovf"}, {31'd0, ovf[u]}, {31'd0, m_ovf[u]});
        chk({tag, "_lerr"}, {31'd0, lerr[u]}, {31'd0, m_lerr[u]});
        chk({tag, "_done"}, done_seen[u], m_done[u]);
        chk({tag, "_busy"}, {31'd0, bsy[u]}, 32'd0);
    endtask

    initial begin
        rst_n = 1'b1;
        for (int u = 0; u < 2; u++) begin
            sys[u] = 1'b0;
            chr[u] = '0;
            rdy[u] = 1'b1;
            tog[u] = 1'b0;
            m_done[u] = 0;
            done_seen[u] = 0;
        end
        model_reset();
        #2 rst_n = 1'b0;
        #1;
        for (int u = 0; u < 2; u++) begin
            chk($sformatf("rst%0d_data", u), {24'd0, odata[u]}, 32'd0);
            chk($sformatf("rst%0d_valid", u), {31'd0, ovalid[u]}, 32'd0);
            chk($sformatf("rst%0d_busy", u), {31'd0, bsy[u]}, 32'd0);
            chk($sformatf("rst%0d_done", u), {31'd0, done[u]}, 32'd0);
            chk($sformatf("rst%0d_len", u), {24'd0, slen[u]}, 32'd0);
            chk($sformatf("rst%0d_ovf", u), {31'd0, ovf[u]}, 32'd0);
            chk($sformatf("rst%0d_lerr", u), {31'd0, lerr[u]}, 32'd0);
        end
        cyc(3);
        rst_n = 1'b1;
        cyc(3);

        // "Hi" then NUL
        pop_log0.delete();
        send_string(0, "Hi", 1'b1);
        cyc(4);
        check_state(0, "hi");
        chk("hi_len_lit", {24'd0, slen[0]}, 32'd2);
        chk("hi_done_lit", done_seen[0], 32'd1);
        chk("hi_npop", pop_log0.size(), 32'd3);
        chk("hi_b0", log_at(0, 0), 32'h48);
        chk("hi_b1", log_at(0, 1), 32'h69);
        chk("hi_b2", log_at(0, 2), 32'h0A);

        // Empty string
        pop_log0.delete();
        send_string(0, "", 1'b1);
        cyc(4);
        check_state(0, "empty");
        chk("empty_len_lit", {24'd0, slen[0]}, 32'd0);
        chk("empty_npop", pop_log0.size(), 32'd1);
        chk("empty_nl", log_at(0, 0), 32'h0A);

        // Consumer stalled: 20 chars into a 16-entry FIFO
        rdy[0] = 1'b0;
        pop_log0.delete();
        send_string(0, "ABCDEFGHIJKLMNOPQRST", 1'b1);
        cyc(4);
        check_state(0, "ovf");
        chk("ovf_len_lit", {24'd0, slen[0]}, 32'd20);
        chk("ovf_flag_lit", {31'd0, ovf[0]}, 32'd1);
        chk("ovf_model_held", q_size(0), 32'd16);
        chk("ovf_valid", {31'd0, ovalid[0]}, 32'd1);
        chk("ovf_head", {24'd0, odata[0]}, 32'h41);
        rdy[0] = 1'b1;
        cyc(20);
        chk("ovf_npop", pop_log0.size(), 32'd16);
        chk("ovf_first", log_at(0, 0), 32'h41);
        chk("ovf_last", log_at(0, 15), 32'h50);
        chk("ovf_drained", {31'd0, ovalid[0]}, 32'd0);

        // Back-to-back string; first byte keeps the previous toggle value
        cyc(2);
        pop_log0.delete();
        send_string(0, "xy", 1'b1);
        cyc(4);
        check_state(0, "b2b");
        chk("b2b_ovf_clr", {31'd0, ovf[0]}, 32'd0);
        chk("b2b_len_lit", {24'd0, slen[0]}, 32'd2);
        chk("b2b_npop", pop_log0.size(), 32'd3);
        chk("b2b_b0", log_at(0, 0), 32'h78);
        chk("b2b_b1", log_at(0, 1), 32'h79);

        // Runaway string on the MAX_LEN=4 unit
        pop_log1.delete();
        send_string(1, "abcdef", 1'b0);
        cyc(4);
        check_state(1, "lerr");
        chk("lerr_flag_lit", {31'd0, lerr[1]}, 32'd1);
        chk("lerr_len_lit", {24'd0, slen[1]}, 32'd4);
        chk("lerr_nodone", done_seen[1], 32'd0);
        chk("lerr_npop", pop_log1.size(), 32'd4);
        chk("lerr_last", log_at(1, 3), 32'h64);
        pop_log1.delete();
        send_string(1, "ok", 1'b1);
        cyc(4);
        check_state(1, "lerr2");
        chk("lerr2_clr", {31'd0, lerr[1]}, 32'd0);
        chk("lerr2_len_lit", {24'd0, slen[1]}, 32'd2);
        chk("lerr2_npop", pop_log1.size(), 32'd3);

        // Reset in the middle of a string with bytes held in the FIFO
        rdy[0] = 1'b0;
        start_syscall(0, 8'h61);
        send_byte(0, 8'h62);
        chk("mid_valid", {31'd0, ovalid[0]}, 32'd1);
        chk("mid_busy", {31'd0, bsy[0]}, 32'd1);
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("mrst_valid", {31'd0, ovalid[0]}, 32'd0);
        chk("mrst_data", {24'd0, odata[0]}, 32'd0);
        chk("mrst_busy", {31'd0, bsy[0]}, 32'd0);
        chk("mrst_len", {24'd0, slen[0]}, 32'd0);
        chk("mrst_valid1", {31'd0, ovalid[1]}, 32'd0);
        cyc(3);
        rst_n = 1'b1;
        rdy[0] = 1'b1;
        cyc(3);
        pop_log0.delete();
        send_string(0, "Hello", 1'b1);
        cyc(4);
        check_state(0, "post");
        chk("post_len_lit", {24'd0, slen[0]}, 32'd5);
        chk("post_npop", pop_log0.size(), 32'd6);
        chk("post_b0", log_at(0, 0), 32'h48);
        chk("post_nl", log_at(0, 5), 32'h0A);

        chk("end_q0_empty", q_size(0), 32'd0);
        chk("end_q1_empty", q_size(1), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
